// File: rtl/systolic_feeder_4_4.sv
// Weight loader and diagonally skewed activation feeder for a 4x4 weight-stationary systolic array.
// All array-facing outputs are registered; lane k of the activation stream is delayed k cycles.
module systolic_feeder_4_4 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      array_clk,
  input  logic                      array_rst_n,
  input  logic                      feed_start,
  input  logic [16*DATA_WIDTH-1:0]  feed_weight,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [4*DATA_WIDTH-1:0]   act_data,
  input  logic                      act_last,
  output logic                      array_mode,
  output logic [3:0]                array_en_up,
  output logic [4*DATA_WIDTH-1:0]   array_data_up,
  output logic [3:0]                array_en_left,
  output logic [4*DATA_WIDTH-1:0]   array_data_left,
  output logic [3:0]                feed_lane_vld,
  output logic                      feed_busy,
  output logic                      feed_done
);
  localparam int ROW_W = 4 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               cnt, cnt_nxt;
  logic [16*DATA_WIDTH-1:0] weight;
  logic                     mode_nxt, ready_nxt, busy_nxt, done_nxt, left_on_nxt;
  logic [ROW_W-1:0]         up_nxt;
  logic [ROW_W-1:0]         col_data;
  logic                     accept;

  // A bubble (no accepted vector) enters the skew lines as a zero column with vld=0.
  assign accept   = act_ready & act_valid;
  assign col_data = accept ? act_data : '0;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    up_nxt      = '0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (feed_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          up_nxt    = feed_weight[3*ROW_W +: ROW_W];
        end
      end
      LOAD: begin
        cnt_nxt = cnt + 2'd1;
        case (cnt)
          2'd0:    up_nxt = weight[2*ROW_W +: ROW_W];
          2'd1:    up_nxt = weight[1*ROW_W +: ROW_W];
          2'd2:    up_nxt = weight[0 +: ROW_W];
          default: begin
            state_nxt = STREAM;
            cnt_nxt   = '0;
          end
        endcase
      end
      STREAM: begin
        if (accept && act_last) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end
      end
      default: begin
        // Three zero shifts carry the last element to lane 3; the fourth cycle presents it.
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    endcase
    mode_nxt    = (state_nxt == LOAD);
    ready_nxt   = (state_nxt == STREAM);
    left_on_nxt = (state_nxt == STREAM) || (state_nxt == DRAIN);
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge array_clk or negedge array_rst_n) begin
    if (!array_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      array_mode    <= 1'b0;
      array_en_up   <= '0;
      array_data_up <= '0;
      array_en_left <= '0;
      act_ready     <= 1'b0;
      feed_busy     <= 1'b0;
      feed_done     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      array_mode    <= mode_nxt;
      array_en_up   <= {4{mode_nxt}};
      array_data_up <= up_nxt;
      array_en_left <= {4{left_on_nxt}};
      act_ready     <= ready_nxt;
      feed_busy     <= busy_nxt;
      feed_done     <= done_nxt;
    end
  end

  always_ff @(posedge array_clk) begin
    if (state == IDLE && feed_start) weight <= feed_weight;
  end

  // Skew stage: lane k is a (k+1)-deep shift line; its last stage drives the array directly.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] line_p [0:k];
    logic        [k:0]            vld_p;

    always_ff @(posedge array_clk or negedge array_rst_n) begin
      if (!array_rst_n) begin
        for (int i = 0; i <= k; i++) line_p[i] <= '0;
        vld_p <= '0;
      end else begin
        line_p[0] <= $signed(col_data[k*DATA_WIDTH +: DATA_WIDTH]);
        vld_p[0]  <= accept;
        for (int i = 1; i <= k; i++) begin
          line_p[i] <= line_p[i-1];
          vld_p[i]  <= vld_p[i-1];
        end
      end
    end

    assign array_data_left[k*DATA_WIDTH +: DATA_WIDTH] = line_p[k];
    assign feed_lane_vld[k]                            = vld_p[k];
  end
endmodule
